// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 1000,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk_i,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       done_o,
    output logic       ack_o,
    output logic       err_o,
    input  logic       kclk_i,
    input  logic       kdata_i,
    output logic       kclk_oe_o,
    output logic       kdata_oe_o
);

    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_XFER,
        S_WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] icnt_q, icnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          kclk_oe_q, kclk_oe_d;
    logic          kdata_oe_q, kdata_oe_d;

    logic kclk_s1_q, kclk_s2_q, kclk_s3_q;
    logic kdata_s1_q, kdata_s2_q;
    logic fe;
    logic [3:0] bit_n;

    assign fe    = kclk_s3_q & ~kclk_s2_q;
    assign bit_n = bit_q + 4'd1;

    always_ff @(posedge clk_i) begin
        if (rst) begin
            kclk_s1_q  <= 1'b1;
            kclk_s2_q  <= 1'b1;
            kclk_s3_q  <= 1'b1;
            kdata_s1_q <= 1'b1;
            kdata_s2_q <= 1'b1;
        end else begin
            kclk_s1_q  <= kclk_i;
            kclk_s2_q  <= kclk_s1_q;
            kclk_s3_q  <= kclk_s2_q;
            kdata_s1_q <= kdata_i;
            kdata_s2_q <= kdata_s1_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q    <= S_IDLE;
            icnt_q     <= '0;
            tcnt_q     <= '0;
            bit_q      <= '0;
            data_q     <= '0;
            par_q      <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            kclk_oe_q  <= 1'b0;
            kdata_oe_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            icnt_q     <= icnt_d;
            tcnt_q     <= tcnt_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            par_q      <= par_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            kclk_oe_q  <= kclk_oe_d;
            kdata_oe_q <= kdata_oe_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        icnt_d     = icnt_q;
        tcnt_d     = tcnt_q;
        bit_d      = bit_q;
        data_d     = data_q;
        par_d      = par_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
        ack_d      = ack_q;
        err_d      = err_q;
        kclk_oe_d  = kclk_oe_q;
        kdata_oe_d = kdata_oe_q;

        case (state_q)
            S_IDLE: begin
                ready_d    = 1'b1;
                kclk_oe_d  = 1'b0;
                kdata_oe_d = 1'b0;
                if (valid_i) begin
                    data_d    = data_i;
                    par_d     = ~^data_i;
                    ack_d     = 1'b0;
                    err_d     = 1'b0;
                    ready_d   = 1'b0;
                    icnt_d    = '0;
                    kclk_oe_d = 1'b1;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                // Device clock edges here are glitches from our own inhibit and are ignored.
                if (icnt_q == INH_LAST) begin
                    kdata_oe_d = 1'b1;
                    state_d    = S_START;
                end else begin
                    icnt_d = icnt_q + 1'b1;
                end
            end
            S_START: begin
                kclk_oe_d  = 1'b0;
                kdata_oe_d = 1'b1;
                tcnt_d     = '0;
                bit_d      = '0;
                state_d    = S_XFER;
            end
            S_XFER, S_WAIT_IDLE: begin
                if (tcnt_q == TMO_LAST) begin
                    kclk_oe_d  = 1'b0;
                    kdata_oe_d = 1'b0;
                    ack_d      = 1'b0;
                    err_d      = 1'b1;
                    done_d     = 1'b1;
                    ready_d    = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (state_q == S_WAIT_IDLE) begin
                        if (kclk_s2_q && kdata_s2_q) begin
                            done_d  = 1'b1;
                            ready_d = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else if (fe) begin
                        bit_d = bit_n;
                        if (bit_n <= 4'd8) begin
                            kdata_oe_d = ~data_q[bit_q[2:0]];
                        end else if (bit_n == 4'd9) begin
                            kdata_oe_d = ~par_q;
                        end else if (bit_n == 4'd10) begin
                            kdata_oe_d = 1'b0;
                        end else begin
                            ack_d   = ~kdata_s2_q;
                            err_d   = kdata_s2_q;
                            state_d = S_WAIT_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                ready_d    = 1'b1;
                kclk_oe_d  = 1'b0;
                kdata_oe_d = 1'b0;
            end
        endcase
    end

    assign ready_o    = ready_q;
    assign done_o     = done_q;
    assign ack_o      = ack_q;
    assign err_o      = err_q;
    assign kclk_oe_o  = kclk_oe_q;
    assign kdata_oe_o = kdata_oe_q;

endmodule
